inst_fetch_unit: RTL and testbench

Instruction fetch controller that drives the program-counter register's write port (`PCWre`, `newAddress`) and reads instruction memory through a request/acknowledge handshake. It presents each fetched word to decode with a valid/ready handshake. It also accepts branch/jump redirects from the execute stage. It is the producer-side counterpart of the PC register in the multi-cycle core.

---
 rtl/inst_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch controller: PC write port, memory request/ack, decode valid/ready, redirects.
// Optional misaligned-PC trap: define IFU_MISALIGN_TRAP_EN.
module inst_fetch_unit #(
    parameter int RESET_SEED_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] currentAddress,
    output logic        PCWre,
    output logic [31:0] newAddress,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        fetch_fault
);

    // state | meaning
    // IDLE  | post-reset wait before sampling currentAddress
    // REQ   | memory read outstanding
    // KILL  | outstanding read will be discarded, then fetch pending target
    // HOLD  | instruction presented to decode
    // FAULT | misaligned PC trapped (trap build only)
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        KILL,
        HOLD
`ifdef IFU_MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_t;

    localparam logic [1:0] SEED_LOAD = 2'(RESET_SEED_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  seed_cnt;
    logic [31:0] pend_addr;
    logic [31:0] tgt;
    logic [31:0] start_addr;
    logic        misaligned;
    logic        unused_bits;

    assign tgt         = {redirect_addr[31:2], 2'b00};
    assign start_addr  = {currentAddress[31:2], 2'b00};
    assign unused_bits = ^{redirect_addr[1:0]};
`ifdef IFU_MISALIGN_TRAP_EN
    assign misaligned  = (currentAddress[1:0] != 2'b00);
`else
    assign misaligned  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (seed_cnt == 2'd0) begin
`ifdef IFU_MISALIGN_TRAP_EN
                state_nxt = misaligned ? FAULT : REQ;
`else
                state_nxt = REQ;
`endif
            end
            REQ: begin
                if (redirect)     state_nxt = mem_ack ? REQ : KILL;
                else if (mem_ack) state_nxt = HOLD;
            end
            HOLD: if (redirect || (inst_valid && inst_ready)) state_nxt = REQ;
            KILL: if (mem_ack) state_nxt = REQ;
`ifdef IFU_MISALIGN_TRAP_EN
            FAULT: if (redirect) state_nxt = REQ;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ) || (state == KILL);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            seed_cnt    <= SEED_LOAD;
            pend_addr   <= '0;
            mem_addr    <= '0;
            PCWre       <= 1'b0;
            newAddress  <= '0;
            inst_valid  <= 1'b0;
            inst_out    <= '0;
            inst_pc     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            PCWre <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_cnt != 2'd0) seed_cnt <= seed_cnt - 2'd1;
                    else if (misaligned)  fetch_fault <= 1'b1;
                    else                  mem_addr <= start_addr;
                end
                REQ: begin
                    if (redirect) begin
                        PCWre      <= 1'b1;
                        newAddress <= tgt;
                        inst_valid <= 1'b0;
                        if (mem_ack) mem_addr  <= tgt;
                        else         pend_addr <= tgt;
                    end else if (mem_ack) begin
                        inst_out   <= mem_rdata;
                        inst_pc    <= mem_addr;
                        inst_valid <= 1'b1;
                        PCWre      <= 1'b1;
                        newAddress <= mem_addr + 32'd4;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        PCWre      <= 1'b1;
                        newAddress <= tgt;
                        inst_valid <= 1'b0;
                        mem_addr   <= tgt;
                    end else if (inst_valid && inst_ready) begin
                        inst_valid <= 1'b0;
                        mem_addr   <= inst_pc + 32'd4;
                    end
                end
                KILL: begin
                    // newest redirect target wins over the stored one
                    if (redirect) begin
                        PCWre      <= 1'b1;
                        newAddress <= tgt;
                        inst_valid <= 1'b0;
                        if (mem_ack) mem_addr  <= tgt;
                        else         pend_addr <= tgt;
                    end else if (mem_ack) begin
                        mem_addr <= pend_addr;
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                FAULT: if (redirect) begin
                    fetch_fault <= 1'b0;
                    PCWre       <= 1'b1;
                    newAddress  <= tgt;
                    mem_addr    <= tgt;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a flag-level behavioural model.
module tb_inst_fetch_unit;

    localparam int SEED = 1;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] currentAddress;
    logic        PCWre;
    logic [31:0] newAddress;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        fetch_fault;

    inst_fetch_unit #(.RESET_SEED_CYCLES(SEED)) dut (
        .CLK(CLK), .Reset(Reset), .currentAddress(currentAddress),
        .PCWre(PCWre), .newAddress(newAddress),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .fetch_fault(fetch_fault)
    );

    always #5 CLK = ~CLK;

`ifdef IFU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase flags rather than a state machine
    bit          m_idle, m_faulted, m_req, m_drop, m_valid, m_pcwre, m_fault;
    int          m_seed;
    logic [31:0] m_addr, m_next, m_inst, m_pc, m_newaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] t;
        t = {redirect_addr[31:2], 2'b00};
        m_pcwre = 1'b0;
        if (Reset) begin
            m_idle = 1; m_seed = SEED; m_faulted = 0; m_req = 0; m_drop = 0;
            m_valid = 0; m_fault = 0; m_addr = 0; m_next = 0; m_inst = 0; m_pc = 0; m_newaddr = 0;
        end else if (m_idle) begin
            m_seed--;
            if (m_seed == 0) begin
                m_idle = 0;
                if (TRAP && currentAddress[1:0] != 2'b00) begin
                    m_faulted = 1; m_fault = 1;
                end else begin
                    m_req = 1; m_addr = {currentAddress[31:2], 2'b00};
                end
            end
        end else if (m_faulted) begin
            if (redirect) begin
                m_faulted = 0; m_fault = 0; m_pcwre = 1; m_newaddr = t; m_req = 1; m_addr = t;
            end
        end else if (redirect) begin
            m_pcwre = 1; m_newaddr = t; m_valid = 0;
            if (m_req && !mem_ack) begin
                m_drop = 1; m_next = t;
            end else begin
                m_req = 1; m_drop = 0; m_addr = t;
            end
        end else if (m_req && mem_ack) begin
            if (m_drop) begin
                m_drop = 0; m_addr = m_next;
            end else begin
                m_valid = 1; m_inst = mem_rdata; m_pc = m_addr;
                m_pcwre = 1; m_newaddr = m_addr + 32'd4; m_req = 0;
            end
        end else if (!m_req && m_valid && inst_ready) begin
            m_valid = 0; m_req = 1; m_addr = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        chk("mem_req",     32'(mem_req),     32'(m_req));
        chk("mem_addr",    mem_addr,         m_addr);
        chk("PCWre",       32'(PCWre),       32'(m_pcwre));
        chk("newAddress",  newAddress,       m_newaddr);
        chk("inst_valid",  32'(inst_valid),  32'(m_valid));
        chk("inst_out",    inst_out,         m_inst);
        chk("inst_pc",     inst_pc,          m_pc);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endtask

    // inputs are set at a falling edge; the model advances, the DUT clocks, then both are compared
    task automatic step();
        mem_rdata = $urandom;
        model_update();
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    initial begin
        Reset = 1; currentAddress = 32'h100; mem_ack = 0; mem_rdata = 0;
        inst_ready = 1; redirect = 0; redirect_addr = 0;
        @(negedge CLK);
        step(); step();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);

        // zero-wait streaming from 0x100
        Reset = 0; step();
        chk("first_req", 32'(mem_req), 32'h1);
        chk("first_addr", mem_addr, 32'h100);
        mem_ack = 1; step();
        chk("pcwre_1", 32'(PCWre), 32'h1);
        chk("newaddr_1", newAddress, 32'h104);
        chk("inst_pc_1", inst_pc, 32'h100);
        mem_ack = 0; step();
        chk("addr_2", mem_addr, 32'h104);
        chk("pcwre_gap", 32'(PCWre), 32'h0);
        mem_ack = 1; step();
        chk("newaddr_2", newAddress, 32'h108);
        mem_ack = 0; step();
        chk("addr_3", mem_addr, 32'h108);
        mem_ack = 1; step();
        chk("newaddr_3", newAddress, 32'h10C);

        // stall in HOLD: no consume, no PC write
        mem_ack = 0; inst_ready = 0;
        for (int i = 0; i < 4; i++) step();
        chk("hold_inst_pc", inst_pc, 32'h108);
        chk("hold_no_pcwre", 32'(PCWre), 32'h0);
        inst_ready = 1; step();
        chk("addr_4", mem_addr, 32'h10C);

        // redirect to 0x203 with the read still outstanding
        redirect = 1; redirect_addr = 32'h203; step();
        chk("redir_pcwre", 32'(PCWre), 32'h1);
        chk("redir_newaddr", newAddress, 32'h200);
        chk("kill_addr_held", mem_addr, 32'h10C);
        redirect = 0; step();
        mem_ack = 1; step();
        chk("after_kill_addr", mem_addr, 32'h200);
        chk("after_kill_valid", 32'(inst_valid), 32'h0);
        step();
        chk("fetch_200_pc", inst_pc, 32'h200);

        // redirect coinciding with a consume in HOLD
        mem_ack = 0; inst_ready = 1; redirect = 1; redirect_addr = 32'h400; step();
        chk("consume_redir_addr", mem_addr, 32'h400);
        chk("consume_redir_valid", 32'(inst_valid), 32'h0);
        redirect = 0;

        // wraparound, then reset in the middle of KILL
        Reset = 1; currentAddress = 32'hFFFF_FFFC; step();
        Reset = 0; step();
        mem_ack = 1; step();
        chk("wrap_newaddr", newAddress, 32'h0);
        mem_ack = 0; step();
        redirect = 1; redirect_addr = 32'h500; step();
        redirect = 0; Reset = 1; step();
        chk("kill_rst_req", 32'(mem_req), 32'h0);
        chk("kill_rst_addr", mem_addr, 32'h0);
        chk("kill_rst_newaddr", newAddress, 32'h0);

`ifdef IFU_MISALIGN_TRAP_EN
        currentAddress = 32'h102; step();
        Reset = 0; step();
        chk("fault_set", 32'(fetch_fault), 32'h1);
        chk("fault_no_req", 32'(mem_req), 32'h0);
        step();
        redirect = 1; redirect_addr = 32'h300; step();
        redirect = 0;
        chk("fault_clear", 32'(fetch_fault), 32'h0);
        chk("fault_fetch", mem_addr, 32'h300);
`endif

        // randomized traffic
        Reset = 0;
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 399) == 0);
            if (Reset) currentAddress = $urandom;
            mem_ack = mem_req && ($urandom_range(0, 2) == 0);
            inst_ready = ($urandom_range(0, 1) == 0);
            redirect = ($urandom_range(0, 7) == 0);
            redirect_addr = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
